imm_gen_pipe: RTL
=================

# imm_gen_pipe

Parametrised, pipelined immediate generator for the datapath's decode stage. Takes a raw 32-bit instruction plus a format select and produces the sign- or zero-extended, and where required shifted, immediate at DATA_W bits. Covers the D-type, CB-type, B-type, I-type and MOVZ formats. Output is registered behind a valid/ready handshake with a one-entry skid buffer, so decode back-pressure never drops an immediate. A saturating counter records illegal format requests.

## Interface
- DATA_W, 64, output immediate width; legal values are 32 or 64
- ERR_W, 8, width of the illegal-request counter
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  instruction/mode presented
- in_ready  output  1  block can accept this cycle
- instr  input  32  raw instruction word
- mode  input  3  format select (imm_pkg::imm_mode_t)
- out_valid  output  1  imm/out_err valid
- out_ready  input  1  consumer accepts this cycle
- imm  output  DATA_W  extended immediate
- out_err  output  1  this output came from an illegal request
- err_cnt  output  ERR_W  saturating count of illegal requests accepted

## Operation
- **Transfer rules.** An input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- **Format decode** (combinational, applied at the input):
  - MODE_D9 = 0: sign-extend instr[20:12].
  - MODE_CB19 = 1: sign-extend instr[23:5], then shift left by 2.
  - MODE_B26 = 2: sign-extend instr[25:0], then shift left by 2.
  - MODE_I12 = 3: zero-extend instr[21:10].
  - MODE_MOVZ = 4: zero-extend instr[20:5], then shift left by 16*instr[22:21].
- **Width rules.** Sign extension replicates the field MSB up to bit DATA_W-1. Shifts are computed at DATA_W and bits above DATA_W-1 are discarded.
- **Illegal requests.** The following are illegal:
  - mode values 5–7;
  - MODE_MOVZ with instr[22] = 1 when DATA_W = 32.
  
  An illegal request yields imm = 0 and out_err = 1. It still flows through the pipeline normally.
- **Error counter.** err_cnt increments by 1 on each accepted illegal input transfer. It saturates at all-ones.
- **Storage.** Two registers hold decoded results: the output register (OUT) and the skid register (SKID).
  - in_ready = !skid_valid, driven from a register.
  - Accept while OUT is empty, or while OUT is transferring this cycle: the result goes to OUT.
  - Accept while OUT is full and stalled: the result goes to SKID.
  - Output transfer with SKID full: SKID moves to OUT. A simultaneous accept is impossible in this case because in_ready = 0.
- **Ordering.** Results leave strictly in input order.

## Timing
- **Reset.** While reset = 0: out_valid = 0, imm = 0, out_err = 0, err_cnt = 0, skid_valid = 0, in_ready = 1.
- **Reset mid-operation.** Reset asserted mid-operation discards OUT and SKID contents immediately (asynchronous). No output transfer occurs after reset deasserts until a new input is accepted.
- **Latency.** An input accepted in cycle N appears on out_valid/imm in cycle N+1.
- **Throughput.** One result per cycle while out_ready stays high.
- **Back-pressure.** The first stalled cycle with a new input fills SKID. in_ready drops the following cycle. Maximum occupancy is 2.
- **Recovery.** In the cycle after out_ready returns, SKID data is presented on imm and in_ready returns to 1.
- **Stability.** imm and out_err stay stable while out_valid && !out_ready.
- **Simultaneous events.** An input and an output transfer in the same cycle with SKID empty leaves occupancy unchanged, and OUT is reloaded.

## Structure
- **Package imm_pkg** holds:
  - typedef enum logic [2:0] imm_mode_t, containing the five modes above;
  - localparams for the field LSB/MSB positions of each format;
  - MOVZ_SHIFT_UNIT = 16.
- **Sub-module imm_decode** (combinational; parameter DATA_W; inputs instr and mode; outputs imm and illegal) is the generalised extender. It is instantiated once, at the input, so both OUT and SKID store decoded values.
- **imm_gen_pipe** holds only the handshake, OUT/SKID registers, and err_cnt.

## Test plan
- **Reset.** DATA_W = 64, hold out_ready = 1. Assert reset mid-stream -> out_valid, imm, err_cnt all 0 the same cycle; in_ready = 1.
- **D9 and B26 decode.** out_ready = 1:
  - MODE_D9 with instr[20:12] = 9'h1FF -> imm = 64'hFFFF_FFFF_FFFF_FFFF next cycle.
  - MODE_B26 with instr[25:0] = 26'h200_0000 -> imm = 64'hFFFF_FFFF_F800_0000.
- **MOVZ and I12.**
  - MODE_MOVZ with instr[20:5] = 16'hABCD, instr[22:21] = 2'b11 -> imm = 64'hABCD_0000_0000_0000.
  - MODE_I12 with instr[21:10] = 12'hFFF -> imm = 64'h0000_0000_0000_0FFF.
- **Back-pressure.** Stream A, B, C with out_ready held low after A is presented -> A held on imm, B lands in SKID, in_ready = 0, C is not accepted. Raise out_ready -> outputs A, B, C in order, each exactly once.
- **Illegal and saturation.** Apply mode = 3'd6 -> imm = 0, out_err = 1, err_cnt = 1. With ERR_W = 2, send 5 illegal requests -> err_cnt holds at 3.
- **DATA_W = 32.**
  - MODE_MOVZ with instr[22:21] = 2'b10 -> out_err = 1, imm = 0.
  - MODE_CB19 with instr[23:5] = 19'h4_0000 -> imm = 32'hFFF0_0000.

Source files
------------

// File: rtl/imm_pkg.sv
// imm_pkg: format selects, field positions and extension helpers for the immediate generator
package imm_pkg;

    typedef enum logic [2:0] {
        MODE_D9   = 3'd0,
        MODE_CB19 = 3'd1,
        MODE_B26  = 3'd2,
        MODE_I12  = 3'd3,
        MODE_MOVZ = 3'd4
    } imm_mode_t;

    localparam int D9_LSB          = 12;
    localparam int D9_MSB          = 20;
    localparam int CB19_LSB        = 5;
    localparam int CB19_MSB        = 23;
    localparam int B26_LSB         = 0;
    localparam int B26_MSB         = 25;
    localparam int I12_LSB         = 10;
    localparam int I12_MSB         = 21;
    localparam int MOVZ_LSB        = 5;
    localparam int MOVZ_MSB        = 20;
    localparam int MOVZ_HW_LSB     = 21;
    localparam int MOVZ_HW_MSB     = 22;
    localparam int MOVZ_SHIFT_UNIT = 16;
    localparam int BR_SHIFT        = 2;

    // Left-justify the field so its MSB lands on bit 63, then shift back arithmetically.
    function automatic logic [63:0] sext_field(input logic [31:0] w, input int lsb, input int msb);
        return 64'($signed(64'(w) << (63 - msb)) >>> (63 - msb + lsb));
    endfunction

    // Same trick with a logical shift, so the upper bits fill with zeros.
    function automatic logic [63:0] zext_field(input logic [31:0] w, input int lsb, input int msb);
        return (64'(w) << (63 - msb)) >> (63 - msb + lsb);
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out handshake bundle
interface imm_gen_pipe_if
    import imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ERR_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    imm_mode_t         mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] imm;
    logic              out_err;
    logic [ERR_W-1:0]  err_cnt;

    modport master (
        output in_valid, instr, mode, out_ready,
        input  in_ready, out_valid, imm, out_err, err_cnt
    );

    modport slave (
        input  in_valid, instr, mode, out_ready,
        output in_ready, out_valid, imm, out_err, err_cnt
    );
endinterface

// File: rtl/imm_decode.sv
// imm_decode: combinational field extraction, extension and shift for every immediate format
module imm_decode
    import imm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr,
    input  imm_mode_t         mode,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);
    logic [63:0] wide;

    // Build the result at 64 bits; narrower outputs simply drop the top half.
    always_comb begin
        wide    = '0;
        illegal = 1'b0;
        case (mode)
            MODE_D9:   wide = sext_field(instr, D9_LSB, D9_MSB);
            MODE_CB19: wide = sext_field(instr, CB19_LSB, CB19_MSB) << BR_SHIFT;
            MODE_B26:  wide = sext_field(instr, B26_LSB, B26_MSB) << BR_SHIFT;
            MODE_I12:  wide = zext_field(instr, I12_LSB, I12_MSB);
            MODE_MOVZ: begin
                wide    = zext_field(instr, MOVZ_LSB, MOVZ_MSB) << (MOVZ_SHIFT_UNIT * instr[MOVZ_HW_MSB:MOVZ_HW_LSB]);
                illegal = (DATA_W == 32) && instr[MOVZ_HW_MSB];
            end
            default:   illegal = 1'b1;
        endcase
    end

    assign imm = illegal ? '0 : wide[DATA_W-1:0];
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decoded immediates behind a registered valid/ready output with a one-entry skid
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ERR_W  = 8
) (
    input logic           clk,
    input logic           reset,
    imm_gen_pipe_if.slave bus
);
    logic [DATA_W-1:0] dec_imm, out_imm, skid_imm;
    logic              dec_ill, out_valid, out_err, skid_valid, skid_err;
    logic [ERR_W-1:0]  err_cnt;
    logic              acc, out_free;

    imm_decode #(.DATA_W(DATA_W)) u_dec (
        .instr   (bus.instr),
        .mode    (bus.mode),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    assign acc      = bus.in_valid && !skid_valid;
    assign out_free = !out_valid || bus.out_ready;

    // OUT refills from SKID first so order is preserved; a stalled OUT diverts new input to SKID.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_err   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_imm    <= skid_imm;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= acc;
                if (acc) begin
                    out_imm <= dec_imm;
                    out_err <= dec_ill;
                end
            end
        end else if (acc) begin
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_err   <= dec_ill;
        end
    end

    // Count accepted illegal requests, sticking at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err_cnt <= '0;
        else if (acc && dec_ill && err_cnt != '1)
            err_cnt <= err_cnt + 1'b1;
    end

    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = out_valid;
    assign bus.imm       = out_imm;
    assign bus.out_err   = out_err;
    assign bus.err_cnt   = err_cnt;
endmodule
